// File: rtl/ram_pkg.sv
// ============================================================================
// Module      : ram_pkg
// Description : Shared definitions for the RAM controller: default bus
//               widths, wait-counter width and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_pkg;

    localparam int C_ADDR_W = 10;  // default memory address width
    localparam int C_DATA_W = 8;   // default memory data width
    localparam int C_WAIT_W = 4;   // wait counter width, covers RD_WAIT 0..15

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_HOLD = 3'd3,
        ST_RD_DATA = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/ram_ctrl_if.sv
// ============================================================================
// Module      : ram_ctrl_if
// Description : Request/response channel between a client and ram_ctrl.
//               master : client side (drives requests, receives responses)
//               slave  : controller side
//   req_valid/req_ready : request handshake, accepted when both are 1
//   req_we/addr/wdata   : request payload
//   rsp_valid/rsp_rdata : one-cycle read completion pulse and its data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

`default_nettype wire

// File: rtl/ram_ctrl.sv
// ============================================================================
// Module      : ram_ctrl
// Description : Single-port synchronous RAM controller. Accepts one request
//               at a time, runs a one-cycle write or a multi-cycle read
//               (address, optional hold, data) and returns read data with a
//               one-cycle rsp_valid pulse. Every access is followed by at
//               least one idle cycle with mem_cs low for bus turnaround.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               bus       - request/response channel (slave modport)
//               mem_addr  - RAM address (registered)
//               mem_data  - shared RAM data bus, driven only while writing
//               mem_cs/rd/wr - registered chip-select and strobes
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_W  = C_ADDR_W,
    parameter int DATA_W  = C_DATA_W,
    parameter int RD_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    ram_ctrl_if.slave         bus,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic              mem_cs,
    output logic              mem_rd,
    output logic              mem_wr
);

    // Counter value loaded on entry to the hold state; unused when RD_WAIT=0.
    localparam logic [C_WAIT_W-1:0] C_WAIT_LOAD =
        (RD_WAIT > 0) ? C_WAIT_W'(RD_WAIT - 1) : '0;

    state_e              state_q,     state_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic [C_WAIT_W-1:0] cnt_q,       cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                mem_cs_q,    mem_cs_d;
    logic                mem_rd_q,    mem_rd_d;
    logic                mem_wr_q,    mem_wr_d;
    logic                drive_q,     drive_d;

    // Ready is also gated by rst so it reads 0 for the whole reset window.
    assign bus.req_ready = (state_q == ST_IDLE) && !rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    assign mem_addr = addr_q;
    assign mem_cs   = mem_cs_q;
    assign mem_rd   = mem_rd_q;
    assign mem_wr   = mem_wr_q;
    assign mem_data = drive_q ? wdata_q : {DATA_W{1'bz}};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    state_d = bus.req_we ? ST_WRITE : ST_RD_ADDR;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_RD_ADDR: begin
                if (RD_WAIT > 0) begin
                    state_d = ST_RD_HOLD;
                    cnt_d   = C_WAIT_LOAD;
                end else begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_RD_DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RD_DATA: begin
                // RAM output has been stable since the RD_ADDR closing edge.
                rsp_valid_d = 1'b1;
                rsp_rdata_d = mem_data;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Memory controls are decoded from the next state and registered, so
        // they line up with the state they belong to and never glitch.
        mem_cs_d = (state_d != ST_IDLE);
        mem_wr_d = (state_d == ST_WRITE);
        mem_rd_d = (state_d == ST_RD_ADDR) || (state_d == ST_RD_HOLD) ||
                   (state_d == ST_RD_DATA);
        drive_d  = (state_d == ST_WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            mem_cs_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            drive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_cs_q    <= mem_cs_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            drive_q     <= drive_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_ctrl.sv
// ============================================================================
// Module      : tb_ram_ctrl
// Description : Self-checking bench for ram_ctrl. Instance A (RD_WAIT=0) and
//               instance B (RD_WAIT=3) each talk to a 1024x8 synchronous RAM
//               model. A reference array tracks expected RAM contents.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_ctrl;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic mon_en = 1'b0;

    // ---------------- instance A: RD_WAIT = 0 ----------------
    ram_ctrl_if #(.ADDR_W(10), .DATA_W(8)) bus_a ();
    logic [9:0] mem_addr_a;
    wire  [7:0] mem_data_a;
    logic mem_cs_a, mem_rd_a, mem_wr_a;

    ram_ctrl #(.ADDR_W(10), .DATA_W(8), .RD_WAIT(0)) u_dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a), .mem_addr(mem_addr_a),
        .mem_data(mem_data_a), .mem_cs(mem_cs_a), .mem_rd(mem_rd_a), .mem_wr(mem_wr_a)
    );

    logic [7:0] ram_a [1024];
    logic [7:0] q_a;
    always @(posedge clk) if (mem_cs_a) begin
        if (mem_wr_a) ram_a[mem_addr_a] <= mem_data_a;
        if (mem_rd_a) q_a <= ram_a[mem_addr_a];
    end
    assign mem_data_a = (mem_cs_a && mem_rd_a) ? q_a : 8'bz;

    // ---------------- instance B: RD_WAIT = 3 ----------------
    ram_ctrl_if #(.ADDR_W(10), .DATA_W(8)) bus_b ();
    logic [9:0] mem_addr_b;
    wire  [7:0] mem_data_b;
    logic mem_cs_b, mem_rd_b, mem_wr_b;

    ram_ctrl #(.ADDR_W(10), .DATA_W(8), .RD_WAIT(3)) u_dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b), .mem_addr(mem_addr_b),
        .mem_data(mem_data_b), .mem_cs(mem_cs_b), .mem_rd(mem_rd_b), .mem_wr(mem_wr_b)
    );

    logic [7:0] ram_b [1024];
    logic [7:0] q_b;
    always @(posedge clk) if (mem_cs_b) begin
        if (mem_wr_b) ram_b[mem_addr_b] <= mem_data_b;
        if (mem_rd_b) q_b <= ram_b[mem_addr_b];
    end
    assign mem_data_b = (mem_cs_b && mem_rd_b) ? q_b : 8'bz;

    // Expected RAM contents behind instance A.
    logic [7:0] exp_a [1024];
    logic [1023:0] valid_a = '0;

    // ---------------- bus protocol monitor ----------------
    logic prev_rd_a = 1'b0, prev_wr_a = 1'b0, prev_rd_b = 1'b0, prev_wr_b = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if ((mem_rd_a && mem_wr_a) || (!mem_cs_a && (mem_rd_a || mem_wr_a))) begin
                n_fail++; $display("FAIL mon_a_strobes: cs=%b rd=%b wr=%b, required rd/wr exclusive and gated by cs", mem_cs_a, mem_rd_a, mem_wr_a);
            end
            n_checks++;
            if (mem_cs_a && mem_rd_a && mem_data_a !== q_a) begin
                n_fail++; $display("FAIL mon_a_bus_drive: mem_data=%h, required RAM output %h while reading", mem_data_a, q_a);
            end
            n_checks++;
            if ((prev_rd_a && mem_wr_a) || (prev_wr_a && (mem_wr_a || mem_rd_a))) begin
                n_fail++; $display("FAIL mon_a_turnaround: prev rd=%b wr=%b now rd=%b wr=%b, required idle cycle between accesses", prev_rd_a, prev_wr_a, mem_rd_a, mem_wr_a);
            end
            n_checks++;
            if ((mem_rd_b && mem_wr_b) || (!mem_cs_b && (mem_rd_b || mem_wr_b))) begin
                n_fail++; $display("FAIL mon_b_strobes: cs=%b rd=%b wr=%b, required rd/wr exclusive and gated by cs", mem_cs_b, mem_rd_b, mem_wr_b);
            end
            n_checks++;
            if (mem_cs_b && mem_rd_b && mem_data_b !== q_b) begin
                n_fail++; $display("FAIL mon_b_bus_drive: mem_data=%h, required RAM output %h while reading", mem_data_b, q_b);
            end
            n_checks++;
            if ((prev_rd_b && mem_wr_b) || (prev_wr_b && (mem_wr_b || mem_rd_b))) begin
                n_fail++; $display("FAIL mon_b_turnaround: prev rd=%b wr=%b now rd=%b wr=%b, required idle cycle between accesses", prev_rd_b, prev_wr_b, mem_rd_b, mem_wr_b);
            end
        end
        prev_rd_a = mem_rd_a; prev_wr_a = mem_wr_a;
        prev_rd_b = mem_rd_b; prev_wr_b = mem_wr_b;
    end

    // ---------------- request drivers (entered/left at posedge+1) ----------------
    task automatic do_req_a(input logic we, input logic [9:0] addr, input logic [7:0] wd,
                            output logic [7:0] rd);
        int n = 0;
        int lat = 0;
        rd = '0;
        bus_a.req_valid = 1'b1; bus_a.req_we = we; bus_a.req_addr = addr; bus_a.req_wdata = wd;
        while (!bus_a.req_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus_a.req_valid = 1'b0;
        n_checks++;
        if (n >= 20) begin
            n_fail++; $display("FAIL a_accept_timeout: req_ready never seen for addr %h", addr);
            return;
        end
        n_checks++;
        if (we && !(mem_cs_a && mem_wr_a && mem_addr_a == addr && mem_data_a === wd)) begin
            n_fail++; $display("FAIL a_write_phase: cs=%b wr=%b addr=%h data=%h, required 1 1 %h %h", mem_cs_a, mem_wr_a, mem_addr_a, mem_data_a, addr, wd);
        end else if (!we && !(mem_cs_a && mem_rd_a && mem_addr_a == addr)) begin
            n_fail++; $display("FAIL a_read_phase: cs=%b rd=%b addr=%h, required 1 1 %h", mem_cs_a, mem_rd_a, mem_addr_a, addr);
        end
        if (we) begin
            exp_a[addr] = wd; valid_a[addr] = 1'b1;
            @(posedge clk); #1;
            n_checks++;
            if (bus_a.req_ready !== 1'b1) begin
                n_fail++; $display("FAIL a_write_ready_return: req_ready=%b, required 1 two edges after accept", bus_a.req_ready);
            end
        end else begin
            for (int k = 1; k <= 12; k++) begin
                @(posedge clk); #1;
                if (bus_a.rsp_valid) begin lat = k; break; end
            end
            rd = bus_a.rsp_rdata;
            n_checks++;
            if (lat != 2) begin
                n_fail++; $display("FAIL a_read_latency: rsp_valid after %0d edges, required 2", lat);
            end
            @(posedge clk); #1;
            n_checks++;
            if (bus_a.rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL a_rsp_pulse: rsp_valid=%b one cycle later, required 0", bus_a.rsp_valid);
            end
        end
    endtask

    task automatic do_req_b(input logic we, input logic [9:0] addr, input logic [7:0] wd,
                            output logic [7:0] rd, output int rd_cycles);
        int n = 0;
        int lat = 0;
        rd = '0; rd_cycles = 0;
        bus_b.req_valid = 1'b1; bus_b.req_we = we; bus_b.req_addr = addr; bus_b.req_wdata = wd;
        while (!bus_b.req_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus_b.req_valid = 1'b0;
        n_checks++;
        if (n >= 20) begin
            n_fail++; $display("FAIL b_accept_timeout: req_ready never seen for addr %h", addr);
            return;
        end
        if (mem_rd_b) rd_cycles++;
        if (we) begin
            @(posedge clk); #1;
        end else begin
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk); #1;
                if (mem_rd_b) rd_cycles++;
                if (bus_b.rsp_valid) begin lat = k; break; end
            end
            rd = bus_b.rsp_rdata;
            n_checks++;
            if (lat != 5) begin
                n_fail++; $display("FAIL b_read_latency: rsp_valid after %0d edges, required 5", lat);
            end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1; bus_a.req_addr = 10'h155; bus_a.req_wdata = 8'hEE;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if (bus_a.req_ready !== 1'b0 || bus_b.req_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: a=%b b=%b, required 0 0", bus_a.req_ready, bus_b.req_ready);
        end
        n_checks++;
        if (bus_a.rsp_valid !== 1'b0 || bus_a.rsp_rdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_rsp: valid=%b rdata=%h, required 0 00", bus_a.rsp_valid, bus_a.rsp_rdata);
        end
        n_checks++;
        if ({mem_cs_a, mem_rd_a, mem_wr_a, mem_cs_b, mem_rd_b, mem_wr_b} !== 6'b0 || mem_addr_a !== 10'h0) begin
            n_fail++; $display("FAIL reset_mem: a cs/rd/wr=%b%b%b addr=%h b=%b%b%b, required all 0", mem_cs_a, mem_rd_a, mem_wr_a, mem_addr_a, mem_cs_b, mem_rd_b, mem_wr_b);
        end
        bus_a.req_valid = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_a.req_ready !== 1'b1 || bus_b.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: a=%b b=%b, required 1 1", bus_a.req_ready, bus_b.req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [7:0] rd;
        do_req_a(1'b1, 10'h3FF, 8'hA5, rd);
        do_req_a(1'b0, 10'h3FF, 8'h00, rd);
        n_checks++;
        if (rd !== 8'hA5) begin
            n_fail++; $display("FAIL write_read_3ff: rdata=%h, required a5", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd;
        logic [7:0] rdv = '0;
        logic saw_gap = 1'b0;
        logic got_rsp = 1'b0;
        int wr_at = 0;
        do_req_a(1'b1, 10'h010, 8'h77, rd);
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0; bus_a.req_addr = 10'h010; bus_a.req_wdata = 8'h00;
        @(posedge clk); #1;              // controller idle, read accepted here
        bus_a.req_we = 1'b1; bus_a.req_wdata = 8'h5A;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (!mem_cs_a) saw_gap = 1'b1;
            if (bus_a.rsp_valid) begin got_rsp = 1'b1; rdv = bus_a.rsp_rdata; end
            if (mem_wr_a) begin wr_at = c; break; end
        end
        n_checks++;
        if (wr_at != 3 || mem_data_a !== 8'h5A) begin
            n_fail++; $display("FAIL b2b_write_start: write at %0d data=%h, required 3 5a", wr_at, mem_data_a);
        end
        bus_a.req_valid = 1'b0;
        exp_a[10'h010] = 8'h5A;
        n_checks++;
        if (!saw_gap) begin
            n_fail++; $display("FAIL b2b_gap: saw_gap=%b, required 1", saw_gap);
        end
        n_checks++;
        if (!got_rsp || rdv !== 8'h77) begin
            n_fail++; $display("FAIL b2b_read_data: got=%b rdata=%h, required 1 77", got_rsp, rdv);
        end
        @(posedge clk); #1;
        do_req_a(1'b0, 10'h010, 8'h00, rd);
        n_checks++;
        if (rd !== 8'h5A) begin
            n_fail++; $display("FAIL b2b_readback: rdata=%h, required 5a", rd);
        end
    endtask

    task automatic test_random();
        logic [7:0] rd;
        logic [9:0] ad;
        logic [7:0] wd;
        int errs = 0;
        for (int i = 0; i < 1024; i++) do_req_a(1'b1, 10'(i), 8'($urandom), rd);
        for (int i = 0; i < 400; i++) begin
            ad = 10'($urandom_range(0, 1023));
            wd = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                do_req_a(1'b1, ad, wd, rd);
            end else begin
                do_req_a(1'b0, ad, 8'h00, rd);
                n_checks++;
                if (!valid_a[ad] || rd !== exp_a[ad]) begin
                    n_fail++; errs++;
                    if (errs < 10) $display("FAIL random_read: addr %h rdata=%h, required %h", ad, rd, exp_a[ad]);
                end
            end
        end
    endtask

    task automatic test_rd_wait();
        logic [7:0] rd;
        int rc;
        do_req_b(1'b1, 10'h000, 8'h3C, rd, rc);
        do_req_b(1'b0, 10'h000, 8'h00, rd, rc);
        n_checks++;
        if (rc != 5) begin
            n_fail++; $display("FAIL rd_wait_rd_cycles: mem_rd high %0d cycles, required 5", rc);
        end
        n_checks++;
        if (rd !== 8'h3C) begin
            n_fail++; $display("FAIL rd_wait_data: rdata=%h, required 3c", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd;
        int rc;
        logic seen = 1'b0;
        bus_b.req_valid = 1'b1; bus_b.req_we = 1'b0; bus_b.req_addr = 10'h000;
        @(posedge clk); #1;              // read accepted
        bus_b.req_valid = 1'b0;
        @(posedge clk); #1;              // now in the hold phase
        n_checks++;
        if (mem_rd_b !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_setup: mem_rd=%b, required 1", mem_rd_b);
        end
        rst_b = 1'b1;
        @(posedge clk); #1;
        if (bus_b.rsp_valid) seen = 1'b1;
        n_checks++;
        if ({mem_cs_b, mem_rd_b, mem_wr_b} !== 3'b000 || bus_b.req_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_strobes: cs/rd/wr=%b%b%b ready=%b, required 000 0", mem_cs_b, mem_rd_b, mem_wr_b, bus_b.req_ready);
        end
        @(posedge clk); #1;
        if (bus_b.rsp_valid) seen = 1'b1;
        rst_b = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus_b.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_ready: req_ready=%b, required 1", bus_b.req_ready);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus_b.rsp_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL reset_mid_no_rsp: rsp_valid seen=%b, required 0", seen);
        end
        do_req_b(1'b0, 10'h000, 8'h00, rd, rc);
        n_checks++;
        if (rd !== 8'h3C) begin
            n_fail++; $display("FAIL reset_mid_recover: rdata=%h, required 3c", rd);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_rd_wait();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
